stage_fetch_data: RTL and testbench
===================================

Name: stage_fetch_data

Overview:
- Pipeline stage that sits directly before the writeback stage and supplies its operand `a_in`.
- For each operation it reads the current data cell at `dp` from DRAM, or takes one byte from the EXT input channel for `OP_IN`.
- It presents the result as `operation`/`a` to the next stage, using the same `ack` / `ack_in` stall handshake as the rest of the pipeline.

Parameters:
- A_WIDTH, 12, DRAM address width.
- D_WIDTH, 8, data cell width; must be >= 8.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- dp  input  A_WIDTH  current data pointer.
- dre  output  1  DRAM read enable.
- da  output  A_WIDTH  DRAM read address.
- dd  input  D_WIDTH  DRAM read data; valid the cycle after `dre`.
- cd  input  8  EXT input byte.
- crda  input  1  EXT byte available.
- cack  output  1  EXT byte consumed this edge.
- operation_in  input  `OPCODE_MSB+1`  one-hot operation from the previous stage.
- ack  output  1  `operation_in` is accepted this edge.
- operation  output reg  `OPCODE_MSB+1`  operation to the next stage; 0 = bubble.
- a  output reg  D_WIDTH  operand to the next stage.
- ack_in  input  1  next stage accepts `operation`/`a` this edge.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - operation=0, a=0, state=S_IDLE.
  - Pending operation, address and data registers cleared.
  - An in-flight DRAM read or EXT transaction is dropped.
- Operation classes:
  - needs_d = OP_INC | OP_DEC | OP_OUT | OP_LOOPBEGIN | OP_LOOPEND.
  - needs_x = OP_IN.
  - All others, and 0, pass through.
- Combinational outputs:
  - da = dp in S_IDLE, otherwise the pending address.
  - dre = (S_IDLE && ack_in && needs_d(operation_in)).
- S_IDLE with ack_in=0: all registers hold; ack=0, dre=0, cack=0.
- S_IDLE with ack_in=1:
  - needs_d: dre=1, ack=1; latch op and dp into the pending registers; operation<=0 (bubble); go to S_DRAM.
  - needs_x with crda=1: cack=1, ack=1; operation<=op; a<={0,cd} (zero-extended).
  - needs_x with crda=0: ack=0, cack=0; operation<=0 (bubble); stay in S_IDLE.
  - Otherwise: ack=1; operation<=operation_in; a<=0.
- S_DRAM (dd valid this cycle), ack=0:
  - ack_in=1: operation<=pending op, a<=dd, go to S_IDLE.
  - ack_in=0: capture dd into the pending data register, go to S_HOLD.
- S_HOLD, ack=0:
  - ack_in=1: operation<=pending op, a<=pending data, go to S_IDLE.
  - ack_in=0: stay.
- Latency and throughput:
  - needs_d: 2 edges from acceptance to `operation`; throughput one op per 2 cycles without stall.
  - Others: 1 edge, one per cycle.
- cack is asserted only in S_IDLE && ack_in && needs_x && crda; at most one byte is consumed per accepted OP_IN.
- With ack_in=0 in any state, `operation` and `a` hold their values (no bubble insertion).
- Multiple one-hot bits set in operation_in: needs_x takes priority over needs_d.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Enabled:
  - Extra inputs wb_dce (1), wb_da (A_WIDTH), wb_dq (D_WIDTH), taken from the writeback stage's DRAM write port.
  - In the S_IDLE accept cycle, if wb_dce && wb_da==dp, wb_dq is captured and a hit flag is set.
  - In S_DRAM, if wb_dce && wb_da==pending address, wb_dq is used and overrides the earlier hit.
  - Otherwise a hit supplies the captured value instead of dd.
  - Writes seen while in S_HOLD to the pending address also update the pending data.
- Disabled: ports absent; data always comes from dd.

Test Plan:
- Reset, then a single OP_INC at dp=0x005, DRAM[5]=0x41, ack_in=1 -> dre pulse with da=0x005; two edges later operation=OP_INC and a=0x41; ack high in the accept cycle only.
- OP_IN with crda=0 for 3 cycles, then crda=1 and cd=0x7A -> ack=0 and bubbles for 3 cycles; then cack is a single pulse, operation=OP_IN and a=0x7A.
- OP_OUT with DRAM[9]=0x33 and ack_in held 0 during S_DRAM for 4 cycles -> S_HOLD keeps a=0x33 after dd changes; released when ack_in=1.
- Pass-through op (e.g. OP_LEFT) back-to-back with ack_in=1 -> one op per cycle, a=0.
- Reset asserted in S_DRAM -> operation=0 immediately (asynchronous); no late output after reset is released.
- FETCH_BYPASS_EN: OP_DEC at dp=0x010 while wb_dce=1, wb_da=0x010, wb_dq=0x5F, and dd=0x60 (stale) -> a=0x5F.

Source files
------------

// File: rtl/stage_fetch_data.sv
// ============================================================================
// stage_fetch_data
// ----------------------------------------------------------------------------
// Pipeline stage placed directly ahead of writeback. For every operation it
// fetches the operand the writeback stage will need:
//   - data-cell ops (INC, DEC, OUT, LOOPBEGIN, LOOPEND) read DRAM at dp,
//   - OP_IN takes one byte from the EXT input channel,
//   - everything else (including the 0 bubble) passes straight through.
// The ack / ack_in stall handshake matches the rest of the pipeline.
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   dp             current data pointer
//   dre, da, dd    DRAM read port (dd valid the cycle after dre)
//   cd, crda, cack EXT input byte, byte available, byte consumed
//   operation_in   one-hot op from the previous stage; ack accepts it
//   operation, a   op and operand to the next stage (operation 0 = bubble)
//   ack_in         next stage accepts operation/a this edge
//
// Optional feature (macro FETCH_BYPASS_EN):
//   Adds wb_dce / wb_da / wb_dq, the writeback stage's DRAM write port, so a
//   write to the cell being fetched is forwarded instead of using stale dd.
// ============================================================================

`ifndef OPCODE_MSB
`define OPCODE_MSB 7
`endif
`ifndef OP_INC
`define OP_INC 0
`endif
`ifndef OP_DEC
`define OP_DEC 1
`endif
`ifndef OP_LEFT
`define OP_LEFT 2
`endif
`ifndef OP_RIGHT
`define OP_RIGHT 3
`endif
`ifndef OP_OUT
`define OP_OUT 4
`endif
`ifndef OP_IN
`define OP_IN 5
`endif
`ifndef OP_LOOPBEGIN
`define OP_LOOPBEGIN 6
`endif
`ifndef OP_LOOPEND
`define OP_LOOPEND 7
`endif

module stage_fetch_data #(
    parameter int A_WIDTH = 12,
    parameter int D_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [A_WIDTH-1:0]   dp,
    output logic                 dre,
    output logic [A_WIDTH-1:0]   da,
    input  logic [D_WIDTH-1:0]   dd,
    input  logic [7:0]           cd,
    input  logic                 crda,
    output logic                 cack,
`ifdef FETCH_BYPASS_EN
    input  logic                 wb_dce,
    input  logic [A_WIDTH-1:0]   wb_da,
    input  logic [D_WIDTH-1:0]   wb_dq,
`endif
    input  logic [`OPCODE_MSB:0] operation_in,
    output logic                 ack,
    output logic [`OPCODE_MSB:0] operation,
    output logic [D_WIDTH-1:0]   a,
    input  logic                 ack_in
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAM,
        S_HOLD
    } state_t;

    state_t state;
    state_t next_state;

    logic [`OPCODE_MSB:0] pend_op;
    logic [A_WIDTH-1:0]   pend_addr;
    logic [D_WIDTH-1:0]   pend_data;

    logic                 needs_x;
    logic                 needs_d;
    logic [D_WIDTH-1:0]   fetched;
    logic [D_WIDTH-1:0]   held;

`ifdef FETCH_BYPASS_EN
    logic                 hit;
    logic [D_WIDTH-1:0]   hit_data;
    logic                 wb_match;
`endif

    // OP_IN wins when a malformed op sets several bits, so needs_d is masked.
    assign needs_x = operation_in[`OP_IN];
    assign needs_d = !needs_x &&
                     (operation_in[`OP_INC] | operation_in[`OP_DEC] |
                      operation_in[`OP_OUT] | operation_in[`OP_LOOPBEGIN] |
                      operation_in[`OP_LOOPEND]);

    // Operand source while waiting for or holding DRAM data. With bypass, a
    // writeback to the pending cell this cycle beats an earlier captured hit,
    // which in turn beats the (possibly stale) DRAM read data.
`ifdef FETCH_BYPASS_EN
    assign wb_match = wb_dce && (wb_da == pend_addr);
    assign fetched  = wb_match ? wb_dq : (hit ? hit_data : dd);
    assign held     = wb_match ? wb_dq : pend_data;
`else
    assign fetched  = dd;
    assign held     = pend_data;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: only data-cell ops leave S_IDLE; a stall after the
    // DRAM cycle parks the fetched value in S_HOLD.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (ack_in && needs_d) begin
                    next_state = S_DRAM;
                end
            end
            S_DRAM: begin
                next_state = ack_in ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                if (ack_in) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Handshake and DRAM port outputs. Nothing is accepted unless the next
    // stage is accepting too, and OP_IN waits for a byte to be available.
    always_comb begin
        ack  = 1'b0;
        dre  = 1'b0;
        cack = 1'b0;
        da   = pend_addr;
        if (state == S_IDLE) begin
            da = dp;
            if (ack_in) begin
                if (needs_x) begin
                    ack  = crda;
                    cack = crda;
                end else if (needs_d) begin
                    ack = 1'b1;
                    dre = 1'b1;
                end else begin
                    ack = 1'b1;
                end
            end
        end
    end

    // Datapath registers. With ack_in low every output register holds, so a
    // stalled result is never replaced by a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            operation <= '0;
            a         <= '0;
            pend_op   <= '0;
            pend_addr <= '0;
            pend_data <= '0;
`ifdef FETCH_BYPASS_EN
            hit       <= 1'b0;
            hit_data  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (ack_in) begin
                        if (needs_x) begin
                            if (crda) begin
                                operation <= operation_in;
                                a         <= D_WIDTH'(cd);
                            end else begin
                                operation <= '0;
                            end
                        end else if (needs_d) begin
                            operation <= '0;
                            pend_op   <= operation_in;
                            pend_addr <= dp;
`ifdef FETCH_BYPASS_EN
                            hit       <= wb_dce && (wb_da == dp);
                            hit_data  <= wb_dq;
`endif
                        end else begin
                            operation <= operation_in;
                            a         <= '0;
                        end
                    end
                end
                S_DRAM: begin
                    if (ack_in) begin
                        operation <= pend_op;
                        a         <= fetched;
                    end else begin
                        pend_data <= fetched;
                    end
                end
                S_HOLD: begin
                    if (ack_in) begin
                        operation <= pend_op;
                        a         <= held;
                    end else begin
                        pend_data <= held;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_fetch_data.sv
// ============================================================================
// tb_stage_fetch_data
// ----------------------------------------------------------------------------
// Self-checking bench for stage_fetch_data. Scenario tasks drive the stage and
// check handshake signals inline; each expected (operation, a) result is pushed
// to a scoreboard queue and popped when the stage hands it to the next stage.
// Define FETCH_BYPASS_EN for both files to exercise the writeback bypass.
// ============================================================================

module tb_stage_fetch_data;

    localparam int A_WIDTH = 12;
    localparam int D_WIDTH = 8;

    localparam logic [7:0] OP_INC       = 8'h01;
    localparam logic [7:0] OP_DEC       = 8'h02;
    localparam logic [7:0] OP_LEFT      = 8'h04;
    localparam logic [7:0] OP_RIGHT     = 8'h08;
    localparam logic [7:0] OP_OUT       = 8'h10;
    localparam logic [7:0] OP_IN        = 8'h20;

    localparam logic [7:0] DD_IDLE      = 8'hA5;

    logic               clk;
    logic               reset;
    logic [A_WIDTH-1:0] dp;
    logic               dre;
    logic [A_WIDTH-1:0] da;
    logic [D_WIDTH-1:0] dd;
    logic [7:0]         cd;
    logic               crda;
    logic               cack;
    logic [7:0]         operation_in;
    logic               ack;
    logic [7:0]         operation;
    logic [D_WIDTH-1:0] a;
    logic               ack_in;
`ifdef FETCH_BYPASS_EN
    logic               wb_dce;
    logic [A_WIDTH-1:0] wb_da;
    logic [D_WIDTH-1:0] wb_dq;
`endif

    logic [D_WIDTH-1:0] mem [0:(1<<A_WIDTH)-1];
    logic [15:0]        sb [$];
    logic [15:0]        sb_exp;

    int checks = 0;
    int passes = 0;

    stage_fetch_data #(
        .A_WIDTH(A_WIDTH),
        .D_WIDTH(D_WIDTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .dp(dp),
        .dre(dre),
        .da(da),
        .dd(dd),
        .cd(cd),
        .crda(crda),
        .cack(cack),
`ifdef FETCH_BYPASS_EN
        .wb_dce(wb_dce),
        .wb_da(wb_da),
        .wb_dq(wb_dq),
`endif
        .operation_in(operation_in),
        .ack(ack),
        .operation(operation),
        .a(a),
        .ack_in(ack_in)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DRAM model: registered read, garbage on the bus when not reading so a
    // design that samples dd late picks up the wrong value.
    always @(posedge clk) begin
        dd <= dre ? mem[da] : DD_IDLE;
    end

    // Scoreboard monitor: a non-bubble operation with ack_in high is consumed
    // by the next stage on the coming edge, so compare it against the queue.
    always @(negedge clk) begin
        if (reset === 1'b1 && ack_in === 1'b1 && operation !== 8'h00) begin
            checks++;
            if (sb.size() == 0) begin
                $display("[TB] FAIL unexpected_output: got op=%h a=%h, required no output", operation, a);
            end else begin
                sb_exp = sb.pop_front();
                if ({operation, a} !== sb_exp)
                    $display("[TB] FAIL scoreboard: got op=%h a=%h, required op=%h a=%h", operation, a, sb_exp[15:8], sb_exp[7:0]);
                else
                    passes++;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        dp           = 12'h123;
        cd           = 8'h00;
        crda         = 1'b0;
        operation_in = 8'h00;
        ack_in       = 1'b0;
`ifdef FETCH_BYPASS_EN
        wb_dce       = 1'b0;
        wb_da        = '0;
        wb_dq        = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({operation, a} !== 16'h0000)
            $display("[TB] FAIL reset_outputs: got op=%h a=%h, required 00 00", operation, a);
        else
            passes++;
        checks++;
        if ({ack, dre, cack, da} !== {1'b0, 1'b0, 1'b0, 12'h123})
            $display("[TB] FAIL reset_handshake: got ack=%b dre=%b cack=%b da=%h, required 0 0 0 123", ack, dre, cack, da);
        else
            passes++;
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_dram_read();
        mem[12'h005] = 8'h41;
        dp           = 12'h005;
        operation_in = OP_INC;
        ack_in       = 1'b1;
        @(negedge clk);
        checks++;
        if ({ack, dre, cack, da} !== {1'b1, 1'b1, 1'b0, 12'h005})
            $display("[TB] FAIL inc_accept: got ack=%b dre=%b cack=%b da=%h, required 1 1 0 005", ack, dre, cack, da);
        else
            passes++;
        sb.push_back({OP_INC, 8'h41});
        next_cycle();
        operation_in = 8'h00;
        dp           = 12'h0FF;
        @(negedge clk);
        checks++;
        if ({ack, dre, da, operation} !== {1'b0, 1'b0, 12'h005, 8'h00})
            $display("[TB] FAIL inc_dram_cycle: got ack=%b dre=%b da=%h op=%h, required 0 0 005 00", ack, dre, da, operation);
        else
            passes++;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_ext_input();
        operation_in = OP_IN;
        crda         = 1'b0;
        cd           = 8'h7A;
        ack_in       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({ack, cack, operation} !== {1'b0, 1'b0, 8'h00})
                $display("[TB] FAIL in_wait_%0d: got ack=%b cack=%b op=%h, required 0 0 00", i, ack, cack, operation);
            else
                passes++;
            next_cycle();
        end
        crda = 1'b1;
        @(negedge clk);
        checks++;
        if ({ack, cack, dre} !== 3'b110)
            $display("[TB] FAIL in_accept: got ack=%b cack=%b dre=%b, required 1 1 0", ack, cack, dre);
        else
            passes++;
        sb.push_back({OP_IN, 8'h7A});
        next_cycle();
        operation_in = 8'h00;
        crda         = 1'b0;
        @(negedge clk);
        checks++;
        if (cack !== 1'b0)
            $display("[TB] FAIL in_single_cack: got cack=%b, required 0", cack);
        else
            passes++;
        next_cycle();
    endtask

    task automatic test_priority();
        mem[12'h020] = 8'h11;
        dp           = 12'h020;
        operation_in = OP_IN | OP_INC;
        crda         = 1'b1;
        cd           = 8'hC3;
        ack_in       = 1'b1;
        @(negedge clk);
        checks++;
        if ({ack, cack, dre} !== 3'b110)
            $display("[TB] FAIL priority_accept: got ack=%b cack=%b dre=%b, required 1 1 0", ack, cack, dre);
        else
            passes++;
        sb.push_back({OP_IN | OP_INC, 8'hC3});
        next_cycle();
        operation_in = 8'h00;
        crda         = 1'b0;
        next_cycle();
    endtask

    task automatic test_hold();
        mem[12'h009] = 8'h33;
        dp           = 12'h009;
        operation_in = OP_OUT;
        ack_in       = 1'b1;
        @(negedge clk);
        checks++;
        if ({ack, dre, da} !== {1'b1, 1'b1, 12'h009})
            $display("[TB] FAIL out_accept: got ack=%b dre=%b da=%h, required 1 1 009", ack, dre, da);
        else
            passes++;
        sb.push_back({OP_OUT, 8'h33});
        next_cycle();
        operation_in = 8'h00;
        ack_in       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({ack, operation} !== {1'b0, 8'h00})
                $display("[TB] FAIL out_stall_%0d: got ack=%b op=%h, required 0 00", i, ack, operation);
            else
                passes++;
            next_cycle();
        end
        ack_in = 1'b1;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops [4];
        ops[0] = OP_LEFT;
        ops[1] = OP_RIGHT;
        ops[2] = OP_LEFT;
        ops[3] = OP_RIGHT;
        ack_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            operation_in = ops[i];
            @(negedge clk);
            checks++;
            if ({ack, dre, cack} !== 3'b100)
                $display("[TB] FAIL b2b_accept_%0d: got ack=%b dre=%b cack=%b, required 1 0 0", i, ack, dre, cack);
            else
                passes++;
            sb.push_back({ops[i], 8'h00});
            next_cycle();
        end
        operation_in = 8'h00;
        next_cycle();
    endtask

    task automatic test_reset_in_dram();
        mem[12'h005] = 8'h41;
        operation_in = OP_IN;
        crda         = 1'b1;
        cd           = 8'h7A;
        ack_in       = 1'b1;
        sb.push_back({OP_IN, 8'h7A});
        next_cycle();
        crda         = 1'b0;
        dp           = 12'h005;
        operation_in = OP_INC;
        next_cycle();
        operation_in = 8'h00;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({operation, a} !== 16'h0000)
            $display("[TB] FAIL async_reset_outputs: got op=%h a=%h, required 00 00", operation, a);
        else
            passes++;
        checks++;
        if ({ack, dre, da} !== {1'b1, 1'b0, 12'h005})
            $display("[TB] FAIL async_reset_idle: got ack=%b dre=%b da=%h, required 1 0 005", ack, dre, da);
        else
            passes++;
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (operation !== 8'h00)
                $display("[TB] FAIL post_reset_quiet_%0d: got op=%h, required 00", i, operation);
            else
                passes++;
            next_cycle();
        end
    endtask

`ifdef FETCH_BYPASS_EN
    task automatic test_bypass();
        mem[12'h010] = 8'h60;
        dp           = 12'h010;
        operation_in = OP_DEC;
        ack_in       = 1'b1;
        wb_dce       = 1'b1;
        wb_da        = 12'h010;
        wb_dq        = 8'h5F;
        sb.push_back({OP_DEC, 8'h5F});
        next_cycle();
        operation_in = 8'h00;
        wb_dce       = 1'b0;
        next_cycle();
        next_cycle();
    endtask
`endif

    initial begin
        for (int i = 0; i < (1 << A_WIDTH); i++) mem[i] = 8'h00;
        test_reset();
        test_dram_read();
        test_ext_input();
        test_priority();
        test_hold();
        test_back_to_back();
        test_reset_in_dram();
`ifdef FETCH_BYPASS_EN
        test_bypass();
`endif
        checks++;
        if (sb.size() != 0)
            $display("[TB] FAIL scoreboard_drain: got %0d pending results, required 0", sb.size());
        else
            passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
